// File: rtl/div_ext.sv
// div_ext: iterative RV32M divide/remainder unit on the CPU ext* port.
// This is the responder side of the start/done handshake. It produces one
// quotient bit per clock using restoring radix-2 division, so latency is fixed.
// Ports:
//   clk    clock (rising edge)
//   rst    synchronous reset, active-low
//   start  request strobe (extStart)
//   func3  100 DIV, 101 DIVU, 110 REM, 111 REMU (extFunc3)
//   a, b   dividend / divisor (extA / extB)
//   r      quotient or remainder (extR), held until the next result or reset
//   done   one-cycle pulse; r is valid while it is high (extDone)
//   busy   high from the first CALC cycle through DONE
module div_ext #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;      // dividend shifts out the top; quotient shifts in the bottom
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] a_lat;    // original dividend, needed for the divide-by-zero remainder
  logic             sel_rem;
  logic             q_neg;
  logic             r_neg;
  logic             b_zero;

  logic             accept_c;
  logic             signed_c;
  logic [WIDTH-1:0] a_abs_c, b_abs_c;
  logic [WIDTH:0]   rem_sh_c;
  logic             ge_c;
  logic [WIDTH-1:0] rem_nx_c;
  logic [WIDTH-1:0] q_fix_c, r_fix_c, res_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept_c) next_state = CALC;
      CALC: if (count == '0) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand conditioning, one restoring step, and sign fix-up
  always_comb begin
    accept_c = start && func3[2];
    signed_c = ~func3[0];
    a_abs_c  = (signed_c && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_abs_c  = (signed_c && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // The trial subtract is one bit wider than the operands, so a remainder
    // with its top bit set still compares correctly after the shift.
    rem_sh_c = {rem, dvd[WIDTH-1]};
    ge_c     = rem_sh_c >= {1'b0, dvs};
    rem_nx_c = ge_c ? WIDTH'(rem_sh_c - {1'b0, dvs}) : rem_sh_c[WIDTH-1:0];

    // MIN / -1 needs no special path: |MIN| / 1 = 2^(W-1) and the signs match.
    q_fix_c = q_neg ? (~dvd + WIDTH'(1)) : dvd;
    r_fix_c = r_neg ? (~rem + WIDTH'(1)) : rem;
    if (b_zero) begin
      q_fix_c = '1;
      r_fix_c = a_lat;
    end
    res_c = sel_rem ? r_fix_c : q_fix_c;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      count   <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      a_lat   <= '0;
      sel_rem <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      b_zero  <= 1'b0;
      r       <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= (next_state == DONE);
      busy <= (next_state != IDLE);
      case (state)
        IDLE: if (accept_c) begin
          dvd     <= a_abs_c;
          dvs     <= b_abs_c;
          rem     <= '0;
          a_lat   <= a;
          sel_rem <= func3[1];
          q_neg   <= signed_c && (a[WIDTH-1] ^ b[WIDTH-1]);
          r_neg   <= signed_c && a[WIDTH-1];
          b_zero  <= (b == '0);
          count   <= CW'(WIDTH - 1);
        end
        CALC: begin
          rem   <= rem_nx_c;
          dvd   <= {dvd[WIDTH-2:0], ge_c};
          count <= count - CW'(1);
        end
        FIX:  r <= res_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ext.sv
// Scoreboard bench for div_ext: stimulus pushes expected results, the monitor
// pops and compares on every done pulse.
module tb_div_ext;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   func3 = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] r;
  logic         done;
  logic         busy;

  logic [W-1:0] expq[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  div_ext #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3),
    .a(a), .b(b), .r(r), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst && done) begin
      done_cnt++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got r=0x%08h expected no done", r);
      end else begin
        check("result", r, expq.pop_front());
      end
    end
  end

  // One start pulse; operands are scrambled after the start edge
  task automatic pulse(input logic [2:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1; func3 = f; a = av; b = bv;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_0003; func3 = 3'b110;
  endtask

  // Wait for done with a bound; reports latency and busy cycles before done
  task automatic wait_done(output int lat, output int busy_pre, output logic busy_at_done);
    lat = -1; busy_pre = 0; busy_at_done = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n; busy_at_done = busy;
        break;
      end
      if (busy) busy_pre++;
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done expected done within 100 cycles");
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp);
    int lat, bp;
    logic bd;
    expq.push_back(exp);
    pulse(f, av, bv);
    wait_done(lat, bp, bd);
    @(negedge clk);
  endtask

  initial begin
    int lat, bp, dc;
    logic bd;
    logic [W-1:0] r_hold;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_r", r, '0);
    check("reset_done", W'(done), '0);
    check("reset_busy", W'(busy), '0);
    rst = 1'b1;
    @(negedge clk);

    // 1: DIVU 100/7 with latency and busy accounting
    expq.push_back(32'd14);
    pulse(F_DIVU, 32'd100, 32'd7);
    wait_done(lat, bp, bd);
    check("latency", W'(lat), 32'd34);
    check("busy_before_done", W'(bp), 32'd33);
    check("busy_at_done", W'(bd), 32'd1);
    @(negedge clk);
    check("busy_after_done", W'(busy), '0);
    check("r_held", r, 32'd14);

    // 2: signed with negative dividend, plus other sign mixes
    run_op(F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op(F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op(F_DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
    run_op(F_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    run_op(F_REMU, 32'd100, 32'd7, 32'd2);

    // 3: divide by zero
    run_op(F_DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    run_op(F_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678);
    run_op(F_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

    // 4: signed overflow
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // 5: large unsigned dividend; a second start while busy is ignored
    dc = done_cnt;
    expq.push_back(32'hFFFF_FFFF);
    pulse(F_DIVU, 32'hFFFF_FFFF, 32'd1);
    repeat (9) @(negedge clk);
    start = 1'b1; func3 = F_DIVU; a = 32'd5; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bp, bd);
    r_hold = r;
    repeat (40) @(negedge clk);
    check("single_done", W'(done_cnt - dc), 32'd1);
    check("r_unchanged", r, 32'hFFFF_FFFF);
    check("r_stable", r, r_hold);

    // 6: reset mid-operation aborts without a done
    dc = done_cnt;
    pulse(F_DIV, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_r", r, '0);
    check("abort_busy", W'(busy), '0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", W'(done_cnt - dc), '0);
    expq.push_back(32'd3);
    pulse(F_DIVU, 32'd9, 32'd3);
    wait_done(lat, bp, bd);
    check("post_reset_latency", W'(lat), 32'd34);
    @(negedge clk);

    // Multiplier ops are not ours
    dc = done_cnt;
    bp = 0;
    pulse(3'b000, 32'd6, 32'd7);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) bp++;
    end
    check("mul_no_busy", W'(bp), '0);
    check("mul_no_done", W'(done_cnt - dc), '0);

    check("queue_drained", W'(expq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
